// File: rtl/sn_uart_tx_sched.sv
// sn_uart_tx_sched: round-robin scheduler sharing one sn_uart_tx serializer
// among P_NUM_REQ byte producers. It latches the granted byte, holds the
// tx_enable/data_to_pc handshake until tx_done, enforces an inter-frame gap
// and aborts a frame whose tx_done never arrives (watchdog).
//
// Ports:
//   clk          system clock, rising edge
//   rst          asynchronous active-low reset
//   req          per-requester level request, held until ack
//   req_data     flattened bytes, requester i at [8i+7:8i]
//   req_ack      one-cycle pulse: byte of requester i latched
//   tx_enable    start/hold frame to the serializer
//   data_to_pc   byte being sent
//   tx_done      frame-complete pulse from the serializer
//   tx_active    serializer busy
//   busy         high in any state except IDLE
//   grant_id     index of current/last granted requester
//   err_timeout  one-cycle pulse on watchdog abort
//
// Optional feature: define SN_UART_TX_SRC_TAG_EN to precede every data frame
// with a tag frame {4'hA, grant_id}, separated by a full gap.
module sn_uart_tx_sched #(
    parameter int unsigned P_NUM_REQ      = 4,
    parameter int unsigned P_GAP_CLKS     = 2,
    parameter int unsigned P_TIMEOUT_CLKS = 1740
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [P_NUM_REQ-1:0]         req,
    input  logic [8*P_NUM_REQ-1:0]       req_data,
    output logic [P_NUM_REQ-1:0]         req_ack,
    output logic                         tx_enable,
    output logic [7:0]                   data_to_pc,
    input  logic                         tx_done,
    input  logic                         tx_active,
    output logic                         busy,
    output logic [$clog2(P_NUM_REQ)-1:0] grant_id,
    output logic                         err_timeout
);
    localparam int unsigned IW = $clog2(P_NUM_REQ);
    localparam int unsigned WW = (P_TIMEOUT_CLKS > 0) ? $clog2(P_TIMEOUT_CLKS + 1) : 1;
    localparam int unsigned GW = $clog2(P_GAP_CLKS + 2);

`ifdef SN_UART_TX_SRC_TAG_EN
    typedef enum logic [1:0] {ST_IDLE, ST_SEND, ST_GAP, ST_TAG} state_t;
`else
    typedef enum logic [1:0] {ST_IDLE, ST_SEND, ST_GAP} state_t;
`endif

    state_t                 state, state_nxt;
    logic [P_NUM_REQ-1:0]   ack_nxt;
    logic                   txen_nxt, busy_nxt, err_nxt;
    logic [7:0]             data_nxt;
    logic [IW-1:0]          gid_nxt, rr_last, rr_nxt;
    logic [WW-1:0]          wd_cnt, wd_nxt;
    logic [GW-1:0]          gap_cnt, gap_nxt;
`ifdef SN_UART_TX_SRC_TAG_EN
    logic [7:0]             hold_q, hold_nxt;
    logic                   pend_q, pend_nxt;
`endif

    logic                   pick_vld;
    logic [IW-1:0]          pick_idx;
    logic [7:0]             pick_data;
    logic                   wd_expire, gap_done;

    // Round-robin pick: nearest set request after rr_last wins, so the
    // search runs farthest-first and the closest hit overwrites.
    always_comb begin
        int unsigned cand;
        cand     = 0;
        pick_vld = 1'b0;
        pick_idx = '0;
        for (int unsigned k = P_NUM_REQ; k >= 1; k--) begin
            cand = (32'(rr_last) + k) % P_NUM_REQ;
            if (req[IW'(cand)]) begin
                pick_vld = 1'b1;
                pick_idx = IW'(cand);
            end
        end
    end

    assign pick_data = req_data[{pick_idx, 3'b000} +: 8];
    assign wd_expire = (P_TIMEOUT_CLKS != 0) && ((32'(wd_cnt) + 32'd1) >= P_TIMEOUT_CLKS);
    assign gap_done  = (32'(gap_cnt) + 32'd1) >= P_GAP_CLKS;

    // Next-state and next-output logic
    always_comb begin
        state_nxt = state;
        ack_nxt   = '0;
        txen_nxt  = tx_enable;
        data_nxt  = data_to_pc;
        gid_nxt   = grant_id;
        rr_nxt    = rr_last;
        err_nxt   = 1'b0;
        wd_nxt    = wd_cnt;
        gap_nxt   = gap_cnt;
`ifdef SN_UART_TX_SRC_TAG_EN
        hold_nxt  = hold_q;
        pend_nxt  = pend_q;
`endif
        unique case (state)
            ST_IDLE: begin
                if (pick_vld) begin
                    ack_nxt[pick_idx] = 1'b1;
                    gid_nxt           = pick_idx;
                    rr_nxt            = pick_idx;
                    txen_nxt          = 1'b1;
                    wd_nxt            = '0;
`ifdef SN_UART_TX_SRC_TAG_EN
                    data_nxt          = {4'hA, 4'(pick_idx)};
                    hold_nxt          = pick_data;
                    pend_nxt          = 1'b1;
                    state_nxt         = ST_TAG;
`else
                    data_nxt          = pick_data;
                    state_nxt         = ST_SEND;
`endif
                end
            end
`ifdef SN_UART_TX_SRC_TAG_EN
            // Tag frame; an abort here drops the pending data byte
            ST_TAG: begin
                if (tx_done || wd_expire) begin
                    txen_nxt  = 1'b0;
                    err_nxt   = ~tx_done;
                    pend_nxt  = tx_done;
                    gap_nxt   = '0;
                    state_nxt = ST_GAP;
                end else begin
                    wd_nxt = wd_cnt + WW'(1);
                end
            end
`endif
            // tx_done has priority over a simultaneous watchdog expiry
            ST_SEND: begin
                if (tx_done || wd_expire) begin
                    txen_nxt  = 1'b0;
                    err_nxt   = ~tx_done;
                    gap_nxt   = '0;
                    state_nxt = ST_GAP;
                end else begin
                    wd_nxt = wd_cnt + WW'(1);
                end
            end
            // Leave only after the minimum gap and once the serializer is idle
            ST_GAP: begin
                if (gap_done && !tx_active) begin
`ifdef SN_UART_TX_SRC_TAG_EN
                    if (pend_q) begin
                        pend_nxt  = 1'b0;
                        txen_nxt  = 1'b1;
                        data_nxt  = hold_q;
                        wd_nxt    = '0;
                        state_nxt = ST_SEND;
                    end else begin
                        state_nxt = ST_IDLE;
                    end
`else
                    state_nxt = ST_IDLE;
`endif
                end else if (!gap_done) begin
                    gap_nxt = gap_cnt + GW'(1);
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
        busy_nxt = (state_nxt != ST_IDLE);
    end

    // State register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Registered outputs and datapath
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            req_ack     <= '0;
            tx_enable   <= 1'b0;
            data_to_pc  <= 8'h00;
            busy        <= 1'b0;
            grant_id    <= '0;
            err_timeout <= 1'b0;
            rr_last     <= IW'(P_NUM_REQ - 1);
            wd_cnt      <= '0;
            gap_cnt     <= '0;
`ifdef SN_UART_TX_SRC_TAG_EN
            hold_q      <= 8'h00;
            pend_q      <= 1'b0;
`endif
        end else begin
            req_ack     <= ack_nxt;
            tx_enable   <= txen_nxt;
            data_to_pc  <= data_nxt;
            busy        <= busy_nxt;
            grant_id    <= gid_nxt;
            err_timeout <= err_nxt;
            rr_last     <= rr_nxt;
            wd_cnt      <= wd_nxt;
            gap_cnt     <= gap_nxt;
`ifdef SN_UART_TX_SRC_TAG_EN
            hold_q      <= hold_nxt;
            pend_q      <= pend_nxt;
`endif
        end
    end

endmodule

// File: tb/tb_sn_uart_tx_sched.sv
// Testbench for sn_uart_tx_sched: a serializer model answers tx_enable with
// tx_done after a fixed frame, a scoreboard queue holds the bytes expected on
// data_to_pc, and monitors check acks, gaps, busy and the watchdog.
module tb_sn_uart_tx_sched;
    localparam int N     = 4;
    localparam int GAP   = 2;
    localparam int TMO   = 50;
    localparam int FRAME = 6;

    logic                 clk = 1'b0;
    logic                 rst;
    logic [N-1:0]         req;
    logic [8*N-1:0]       req_data;
    logic [N-1:0]         req_ack;
    logic                 tx_enable;
    logic [7:0]           data_to_pc;
    logic                 tx_done   = 1'b0;
    logic                 tx_active = 1'b0;
    logic                 busy;
    logic [$clog2(N)-1:0] grant_id;
    logic                 err_timeout;

    sn_uart_tx_sched #(
        .P_NUM_REQ     (N),
        .P_GAP_CLKS    (GAP),
        .P_TIMEOUT_CLKS(TMO)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .req        (req),
        .req_data   (req_data),
        .req_ack    (req_ack),
        .tx_enable  (tx_enable),
        .data_to_pc (data_to_pc),
        .tx_done    (tx_done),
        .tx_active  (tx_active),
        .busy       (busy),
        .grant_id   (grant_id),
        .err_timeout(err_timeout)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d (0x%0h) want %0d (0x%0h) at %0t", name, act, act, exp, exp, $time);
        end
    endtask

    // Scoreboard of bytes expected on the serializer, in order
    logic [7:0] exp_q[$];
    int ack_cnt[N]  = '{default: 0};
    int exp_acks[N] = '{default: 0};
    int errs = 0;

    function automatic logic [7:0] first_byte(input int id, input logic [7:0] b);
`ifdef SN_UART_TX_SRC_TAG_EN
        return {4'hA, 4'(id)};
`else
        return b;
`endif
    endfunction

    task automatic push_exp(input int id, input logic [7:0] b);
        exp_q.push_back(first_byte(id, b));
`ifdef SN_UART_TX_SRC_TAG_EN
        exp_q.push_back(b);
`endif
    endtask

    // Serializer model and monitors, evaluated on the falling edge
    int   cyc = 0, ser_cnt = 0, tail_cnt = 0, tail_cfg = 0, en_len = 0;
    int   done_cyc = -1000, fall_cyc = -1000, act_fall_cyc = -1000;
    bit   en_prev = 1'b0, busy_prev = 1'b0, ser_hang = 1'b0, force_done = 1'b0;
    bit   done_this = 1'b0, data_stable = 1'b1;
    logic [7:0] data_start = 8'h00;

    always @(negedge clk) begin
        cyc++;
        tx_done = 1'b0;
        if (!rst) begin
            tx_active = 1'b0;
            ser_cnt   = 0;
            tail_cnt  = 0;
            en_prev   = 1'b0;
            busy_prev = 1'b0;
            fall_cyc  = cyc;
        end else begin
            if (req_ack != '0) begin
                chk("ack_onehot", int'($onehot(req_ack)), 1);
                chk("ack_with_txen_rise", int'(tx_enable && !en_prev), 1);
                for (int i = 0; i < N; i++) begin
                    if (req_ack[i]) begin
                        ack_cnt[i]++;
                        chk("ack_grant_id", int'(grant_id), i);
                    end
                end
            end
            if (err_timeout) begin
                errs++;
                chk("wd_txen_low", int'(tx_enable), 0);
                chk("wd_send_len", en_len, TMO);
            end
            if (tx_enable && !en_prev) begin
                chk("gap_before_frame", int'((cyc - fall_cyc) >= GAP), 1);
                if (exp_q.size() == 0) chk("sb_unexpected_frame", int'(data_to_pc), -1);
                else                   chk("sb_byte", int'(data_to_pc), int'(exp_q.pop_front()));
                data_start  = data_to_pc;
                data_stable = 1'b1;
                en_len      = 1;
                done_this   = 1'b0;
                if (!ser_hang) begin
                    ser_cnt   = FRAME;
                    tx_active = 1'b1;
                end
            end else if (tx_enable) begin
                en_len++;
                if (data_to_pc != data_start) data_stable = 1'b0;
            end else if (en_prev) begin
                fall_cyc = cyc;
                chk("data_stable", int'(data_stable), 1);
                if (done_this) chk("txen_drop_after_done", cyc - done_cyc, 1);
            end
            if (busy_prev && !busy) begin
                chk("busy_after_frame", int'((cyc - fall_cyc) >= GAP), 1);
                chk("busy_after_active", int'((cyc - act_fall_cyc) >= 1), 1);
            end
            if (ser_cnt > 0) begin
                ser_cnt--;
                if (ser_cnt == 0) begin
                    tx_done   = 1'b1;
                    done_this = 1'b1;
                    done_cyc  = cyc;
                    if (tail_cfg == 0) begin
                        tx_active    = 1'b0;
                        act_fall_cyc = cyc;
                    end else begin
                        tail_cnt = tail_cfg;
                    end
                end
            end else if (tail_cnt > 0) begin
                tail_cnt--;
                if (tail_cnt == 0) begin
                    tx_active    = 1'b0;
                    act_fall_cyc = cyc;
                end
            end
            if (force_done) begin
                tx_done    = 1'b1;
                force_done = 1'b0;
            end
            en_prev   = tx_enable;
            busy_prev = busy;
        end
    end

    task automatic wait_ack(input string name, input logic [N-1:0] exp);
        int n;
        n = 0;
        for (int i = 0; i < N; i++) if (exp[i]) exp_acks[i]++;
        do begin
            @(negedge clk);
            n++;
        end while (req_ack == '0 && n < 3000);
        chk(name, int'(req_ack), int'(exp));
    endtask

    task automatic wait_idle(input string name);
        int n;
        n = 0;
        while ((busy || tx_enable) && n < 3000) begin
            @(negedge clk);
            n++;
        end
        chk(name, int'(busy), 0);
    endtask

    typedef struct {
        logic [N-1:0]   req;
        logic [8*N-1:0] data;
        int             tail;
        logic [N-1:0]   ack;
        int             gid;
        logic [7:0]     byt;
    } vec_t;

    vec_t vec[6];

    initial begin
        int a0[N];
        vec[0] = '{4'b0001, 32'h443322F0, 0, 4'b0001, 0, 8'hF0};
        vec[1] = '{4'b0101, 32'hA1B2C3D4, 4, 4'b0100, 2, 8'hB2};
        vec[2] = '{4'b1001, 32'h5E6F7A8B, 0, 4'b1000, 3, 8'h5E};
        vec[3] = '{4'b0110, 32'h01020304, 3, 4'b0010, 1, 8'h03};
        vec[4] = '{4'b0011, 32'hCAFEBABE, 0, 4'b0001, 0, 8'hBE};
        vec[5] = '{4'b1000, 32'h12345678, 0, 4'b1000, 3, 8'h12};

        rst      = 1'b0;
        req      = '0;
        req_data = '0;
        #1;
        chk("rst_ack", int'(req_ack), 0);
        chk("rst_txen", int'(tx_enable), 0);
        chk("rst_data", int'(data_to_pc), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_gid", int'(grant_id), 0);
        chk("rst_err", int'(err_timeout), 0);
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);

        // Single grants from IDLE: ack and tx_enable exactly one clock later
        for (int v = 0; v < 6; v++) begin
            tail_cfg = vec[v].tail;
            push_exp(vec[v].gid, vec[v].byt);
            exp_acks[vec[v].gid]++;
            req_data = vec[v].data;
            req      = vec[v].req;
            @(negedge clk);
            chk("vec_ack", int'(req_ack), int'(vec[v].ack));
            chk("vec_gid", int'(grant_id), vec[v].gid);
            chk("vec_txen", int'(tx_enable), 1);
            chk("vec_busy", int'(busy), 1);
            chk("vec_data", int'(data_to_pc), int'(first_byte(vec[v].gid, vec[v].byt)));
            req = '0;
            wait_idle("vec_idle");
        end
        tail_cfg = 0;

        // All requesters held: 11, 22, 33, 44, 11
        for (int i = 0; i < N; i++) a0[i] = ack_cnt[i];
        req_data = 32'h44332211;
        push_exp(0, 8'h11);
        push_exp(1, 8'h22);
        push_exp(2, 8'h33);
        push_exp(3, 8'h44);
        push_exp(0, 8'h11);
        req = 4'b1111;
        wait_ack("all_ack0", 4'b0001);
        wait_ack("all_ack1", 4'b0010);
        wait_ack("all_ack2", 4'b0100);
        wait_ack("all_ack3", 4'b1000);
        wait_ack("all_ack0b", 4'b0001);
        req = '0;
        wait_idle("all_idle");
        chk("all_cnt0", ack_cnt[0] - a0[0], 2);
        chk("all_cnt1", ack_cnt[1] - a0[1], 1);
        chk("all_cnt2", ack_cnt[2] - a0[2], 1);
        chk("all_cnt3", ack_cnt[3] - a0[3], 1);

        // tx_done while idle is ignored
        force_done = 1'b1;
        repeat (4) @(negedge clk);
        chk("idle_done_busy", int'(busy), 0);
        chk("idle_done_txen", int'(tx_enable), 0);

        // Fairness: req[0] held, req[2] raised mid-frame -> 2 then 0
        req_data = 32'h00C000A0;
        push_exp(0, 8'hA0);
        req = 4'b0001;
        wait_ack("fair_ack0", 4'b0001);
        repeat (2) @(negedge clk);
        push_exp(2, 8'hC0);
        push_exp(0, 8'hA0);
        req = 4'b0101;
        wait_ack("fair_ack2", 4'b0100);
        wait_ack("fair_ack0b", 4'b0001);
        req = '0;
        wait_idle("fair_idle");

        // Watchdog: no tx_done, abort after TMO cycles, then serve next request
        ser_hang = 1'b1;
        req_data = 32'h00007700;
        exp_q.push_back(first_byte(1, 8'h77));
        req = 4'b0010;
        wait_ack("wd_ack", 4'b0010);
        req = '0;
        wait_idle("wd_idle");
        chk("wd_err_count", errs, 1);
        ser_hang = 1'b0;
        req_data = 32'h00990000;
        push_exp(2, 8'h99);
        req = 4'b0100;
        wait_ack("wd_next_ack", 4'b0100);
        req = '0;
        wait_idle("wd_next_idle");

        // Reset mid-frame: outputs drop asynchronously, req[0] wins afterwards
        req_data = 32'h00550000;
        exp_q.push_back(first_byte(2, 8'h55));
        req = 4'b0100;
        wait_ack("rstm_ack", 4'b0100);
        req = '0;
        repeat (3) @(negedge clk);
        #2 rst = 1'b0;
        #1;
        chk("rstm_txen", int'(tx_enable), 0);
        chk("rstm_busy", int'(busy), 0);
        chk("rstm_gid", int'(grant_id), 0);
        chk("rstm_data", int'(data_to_pc), 0);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        req_data = 32'h44332211;
        push_exp(0, 8'h11);
        req = 4'b1111;
        wait_ack("rstm_first", 4'b0001);
        req = '0;
        wait_idle("rstm_idle");

        repeat (5) @(negedge clk);
        chk("err_total", errs, 1);
        chk("sb_empty", exp_q.size(), 0);
        for (int i = 0; i < N; i++) chk("ack_total", ack_cnt[i], exp_acks[i]);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL global_timeout: simulation did not finish, got running want done");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/sn_uart_tx_sched.md
Name: sn_uart_tx_sched

Overview:
- Round-robin scheduler that shares one sn_uart_tx serializer among P_NUM_REQ byte producers (neuron spike reporters, status/debug sources).
- Latches the granted requester's byte, drives the serializer's tx_enable/data_to_pc handshake and holds it until tx_done.
- Enforces an inter-frame gap and a watchdog on tx_done.
- Sits between the neuron array's reporting logic and the UART TX pin path.

Parameters:
- P_NUM_REQ, 4: number of requesters; legal range 2..16.
- P_GAP_CLKS, 2: minimum idle clocks between the end of one frame and the next tx_enable.
- P_TIMEOUT_CLKS, 1740: maximum clocks in SEND without tx_done before abort. Default is 2 x 87 x 10. Value 0 disables the watchdog.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- rst  in  1  asynchronous, active-low reset.
- req  in  P_NUM_REQ  per-requester send request; level, held until ack.
- req_data  in  8*P_NUM_REQ  flattened bytes; requester i uses bits [8i+7:8i].
- req_ack  out  P_NUM_REQ  one-cycle pulse; byte of requester i latched.
- tx_enable  out  1  to sn_uart_tx; start/hold frame.
- data_to_pc  out  8  to sn_uart_tx; byte being sent.
- tx_done  in  1  from sn_uart_tx; frame-complete pulse.
- tx_active  in  1  from sn_uart_tx; serializer busy.
- busy  out  1  high in any state except IDLE.
- grant_id  out  $clog2(P_NUM_REQ)  index of the current/last granted requester.
- err_timeout  out  1  one-cycle pulse on watchdog abort.

Behaviour:
- Reset (rst=0, asynchronous):
  - state=IDLE; req_ack=0, tx_enable=0, data_to_pc=0, busy=0, grant_id=0, err_timeout=0.
  - Round-robin pointer rr_last=P_NUM_REQ-1, so req[0] has first priority.
  - Reset mid-frame aborts immediately; the byte is lost and no ack is re-issued.
- Outputs: all registered; no combinational path from inputs to outputs.
- States: IDLE, SEND, GAP (TAG added with the optional feature).
- IDLE:
  - On an edge with req!=0, select the first set bit searching rr_last+1, rr_last+2, ... mod P_NUM_REQ.
  - Next cycle:
    - req_ack[i]=1 for exactly one cycle;
    - data_to_pc=req_data[i] as sampled at that edge;
    - grant_id=i, rr_last=i, busy=1;
    - tx_enable=1, state=SEND.
  - Latency from req sampled to tx_enable high: 1 clock.
  - A requester keeping req high after its ack is a new request. It is served only after every other pending requester.
- SEND:
  - tx_enable stays 1 and data_to_pc is stable.
  - On the edge where tx_done=1 is sampled: next cycle tx_enable=0, state=GAP, gap counter cleared.
  - req changes while in SEND are ignored until IDLE.
- Watchdog:
  - Counter is cleared on SEND entry and increments each SEND cycle.
  - If it reaches P_TIMEOUT_CLKS with no tx_done: next cycle tx_enable=0, err_timeout=1 for one cycle, state=GAP. The byte is dropped.
  - The counter is wide enough for P_TIMEOUT_CLKS with no wrap.
  - tx_done and timeout in the same cycle: tx_done wins, no error.
- GAP:
  - Count P_GAP_CLKS cycles.
  - Return to IDLE only when the count is complete and tx_active=0. Stay in GAP while tx_active=1, with no limit.
  - busy drops in the same cycle as the IDLE entry.
- tx_done outside SEND is ignored.
- data_to_pc holds its last value while idle.

Optional Feature:
- Macro: SN_UART_TX_SRC_TAG_EN.
- Defined:
  - Each grant sends two frames: a tag byte {4'hA, grant_id zero-extended to 4 bits}, then the data byte.
  - Added state TAG precedes SEND. It uses the same tx_enable/tx_done handshake and watchdog.
  - A full GAP is inserted between the tag frame and the data frame.
  - req_ack pulses once, at grant; the data byte is latched then.
  - A watchdog abort in TAG skips the data byte and goes to GAP.
- Undefined: one frame per grant; the TAG state is not built.

Test Plan:
- Single request: req=4'b0001, req_data[7:0]=8'hF0. Required: req_ack=0001 one cycle later; tx_enable=1 with data_to_pc=F0 until tx_done; tx_enable=0 the next cycle; busy low at least 2 clocks after tx_active falls.
- All requesters at once: req=4'b1111 held, bytes 11/22/33/44. Required: frame order 11, 22, 33, 44, 11; each ack pulses exactly once per frame; gaps between frames are at least P_GAP_CLKS.
- Fairness: req[0] held high continuously and req[2] raised mid-frame. Required: next grant goes to 2, then 0.
- Watchdog: P_TIMEOUT_CLKS=50 and tx_done tied low. Required: err_timeout pulses at cycle 50 of SEND; tx_enable drops; scheduler returns to IDLE and serves the next request.
- Reset mid-frame: rst=0 during SEND. Required: tx_enable=0 and busy=0 asynchronously; after release req[0] wins first.
- With SN_UART_TX_SRC_TAG_EN: req=4'b0100, byte 5A. Required: frames A2 then 5A; single ack pulse.
